mem_stall_ctrl: RTL
===================

MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- DataWidth, 32, data bus width
- AddrWidth, 32, address width
- TimeoutCycles, 255, max bus wait before abort; legal range 2..255
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk_i, in, 1, sole clock
- rst_ni, in, 1, asynchronous active-low reset
- mem_rd_i, in, 1, core load request, level, held by core while stalled
- mem_wr_i, in, 1, core store request, level
- addr_i, in, AddrWidth, core access address
- wdata_i, in, DataWidth, core store data
- be_i, in, DataWidth/8, core byte enables
- halt_o, out, 1, stall to core PC/pipeline registers (drives halt_i of flop_reg)
- rdata_o, out, DataWidth, registered load data to core
- err_o, out, 1, access error/timeout flag
- req_o, out, 1, bus request
- we_o, out, 1, bus write enable
- addr_o, out, AddrWidth, bus address
- wdata_o, out, DataWidth, bus write data
- be_o, out, DataWidth/8, bus byte enables
- gnt_i, in, 1, bus grant (request accepted)
- rvalid_i, in, 1, bus response valid
- rdata_i, in, DataWidth, bus read data
- berr_i, in, 1, bus error, qualified by rvalid_i

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-004 IDLE, exactly one of mem_rd_i/mem_wr_i high: latch addr_i, wdata_i, be_i, we=mem_wr_i into addr_o/wdata_o/be_o/we_o; next state REQ.
REQ-005 IDLE, mem_rd_i and mem_wr_i both high: no bus access; set err_o; next state DONE.
REQ-006 halt_o SHALL be combinational: 1 when (IDLE and (mem_rd_i or mem_wr_i)), or in REQ or WAIT; 0 in DONE and in idle IDLE.
REQ-007 req_o SHALL be 1 only in REQ; bus outputs stable while req_o=1.
REQ-008 REQ, gnt_i=1 and rvalid_i=0: next state WAIT.
REQ-009 REQ, gnt_i=1 and rvalid_i=1: complete as REQ-010 in the same cycle; next state DONE.
REQ-010 WAIT, rvalid_i=1: if read, rdata_o<=rdata_i; err_o<=berr_i; next state DONE.
REQ-011 Write completion SHALL leave rdata_o unchanged.
REQ-012 Wait counter SHALL clear on IDLE->REQ and increment each cycle in REQ/WAIT; on reaching TimeoutCycles without completion: err_o<=1, rdata_o<=0 for reads, req_o drops, next state DONE.
REQ-013 A response arriving in the same cycle as the timeout SHALL win (normal completion, no timeout error).
REQ-014 DONE SHALL last exactly one cycle with halt_o=0, letting the core retire the instruction with rdata_o/err_o valid; DONE SHALL ignore mem_rd_i/mem_wr_i; next state IDLE.
REQ-015 err_o SHALL be 0 in every cycle except DONE.
REQ-016 Min access latency: 3 cycles from request to DONE (IDLE, REQ with gnt+rvalid, DONE); the core is halted for 2 cycles.
REQ-017 rvalid_i outside REQ/WAIT and gnt_i outside REQ SHALL be ignored.

Reset
REQ-018 While rst_ni=0, asynchronously: state=IDLE, counter=0, rdata_o=0, err_o=0, req_o=0, we_o=0, addr_o=0, wdata_o=0, be_o=0.
REQ-019 Reset mid-transaction SHALL abandon the access with no completion and no error; after release, halt_o follows REQ-006 from IDLE.

Verification
REQ-020 Read, gnt and rvalid in the same REQ cycle with rdata_i=0xDEADBEEF -> halt_o high for 2 cycles, DONE shows rdata_o=0xDEADBEEF, err_o=0.
REQ-021 Write addr 0x100, wdata 0x12345678, be 0xF, gnt after 3 cycles, rvalid 2 cycles later -> req_o held 4 cycles with stable bus outputs, we_o=1, rdata_o unchanged.
REQ-022 Read, never granted, TimeoutCycles=8 -> err_o=1 and rdata_o=0 in DONE, req_o low after abort.
REQ-023 Read with rvalid_i and berr_i set -> err_o=1 in DONE only.
REQ-024 mem_rd_i=mem_wr_i=1 -> no req_o, DONE next cycle with err_o=1.
REQ-025 rst_ni low during WAIT -> all outputs at reset values immediately; no DONE cycle.

Source files
------------

// File: rtl/mem_stall_ctrl.sv
// Load/store stall controller: holds the core while a single bus access is
// requested, waited on and completed, then presents load data/error for one retire cycle.
//
// state | meaning
// IDLE  | no access in flight; a core request is latched onto the bus
// REQ   | req_o asserted, waiting for gnt_i (response may arrive with grant)
// WAIT  | granted, waiting for rvalid_i
// DONE  | one-cycle retire window: core unhalted, rdata_o/err_o valid
module mem_stall_ctrl #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   mem_rd_i,
    input  logic                   mem_wr_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] be_i,
    output logic                   halt_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   err_o,
    output logic                   req_o,
    output logic                   we_o,
    output logic [AddrWidth-1:0]   addr_o,
    output logic [DataWidth-1:0]   wdata_o,
    output logic [DataWidth/8-1:0] be_o,
    input  logic                   gnt_i,
    input  logic                   rvalid_i,
    input  logic [DataWidth-1:0]   rdata_i,
    input  logic                   berr_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    // The access may spend at most TimeoutCycles cycles in REQ/WAIT; the
    // counter holds the index of the current cycle, so the last one is TimeoutCycles-1.
    localparam logic [7:0] CntLast = 8'(TimeoutCycles - 1);

    state_e     state;
    logic [7:0] wait_cnt;
    logic       rsp_done;
    logic       timeout_hit;

    assign rsp_done    = ((state == REQ) && gnt_i && rvalid_i) ||
                         ((state == WAIT) && rvalid_i);
    assign timeout_hit = (wait_cnt == CntLast);

    assign halt_o = ((state == IDLE) && (mem_rd_i || mem_wr_i)) ||
                    (state == REQ) || (state == WAIT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
            req_o    <= 1'b0;
            we_o     <= 1'b0;
            addr_o   <= '0;
            wdata_o  <= '0;
            be_o     <= '0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_rd_i && mem_wr_i) begin
                        err_o <= 1'b1;
                        state <= DONE;
                    end else if (mem_rd_i || mem_wr_i) begin
                        addr_o   <= addr_i;
                        wdata_o  <= wdata_i;
                        be_o     <= be_i;
                        we_o     <= mem_wr_i;
                        req_o    <= 1'b1;
                        wait_cnt <= 8'd0;
                        state    <= REQ;
                    end
                end
                REQ, WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    // A response in the timeout cycle still completes normally.
                    if (rsp_done) begin
                        req_o <= 1'b0;
                        err_o <= berr_i;
                        if (!we_o) begin
                            rdata_o <= rdata_i;
                        end
                        state <= DONE;
                    end else if (timeout_hit) begin
                        req_o <= 1'b0;
                        err_o <= 1'b1;
                        if (!we_o) begin
                            rdata_o <= '0;
                        end
                        state <= DONE;
                    end else if ((state == REQ) && gnt_i) begin
                        req_o <= 1'b0;
                        state <= WAIT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
